// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
// Extracts and extends I/S/B/J/U/SHAMT/ZIMM immediates to XLEN bits and
// registers each result behind a valid/ready handshake. A one-entry skid
// register absorbs the request that arrives while the output stalls.
// Because of the skid register, in_ready is a pure register and has no
// combinational path from out_ready. A saturating counter records how many
// reserved-format requests were accepted.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ins,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_fmt_err,
    output logic [7:0]       err_count
);

    localparam logic [2:0] FMT_I     = 3'b000;
    localparam logic [2:0] FMT_S     = 3'b001;
    localparam logic [2:0] FMT_B     = 3'b010;
    localparam logic [2:0] FMT_J     = 3'b011;
    localparam logic [2:0] FMT_U     = 3'b100;
    localparam logic [2:0] FMT_SHAMT = 3'b101;
    localparam logic [2:0] FMT_ZIMM  = 3'b110;
    localparam logic [2:0] FMT_RSV   = 3'b111;

    // Sign-extending formats start from a word filled with ins[31], and
    // each case then overwrites the low bits it defines.
    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins,
                                                input logic [2:0]  fmt);
        logic [XLEN-1:0] imm;
        imm = {XLEN{ins[31]}};
        case (fmt)
            FMT_I:     imm[11:0] = ins[31:20];
            FMT_S:     imm[11:0] = {ins[31:25], ins[11:7]};
            FMT_B:     imm[12:0] = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_J:     imm[20:0] = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_U:     imm[31:0] = {ins[31:12], 12'h000};
            FMT_SHAMT: begin
                // RV64 shift amounts use six bits; RV32 uses five.
                imm      = {XLEN{1'b0}};
                imm[5:0] = {((XLEN == 64) ? ins[25] : 1'b0), ins[24:20]};
            end
            FMT_ZIMM:  begin
                imm      = {XLEN{1'b0}};
                imm[4:0] = ins[19:15];
            end
            default:   imm = {XLEN{1'b0}};
        endcase
        return imm;
    endfunction

    logic             out_valid_q,   out_valid_d;
    logic [XLEN-1:0]  out_imm_q,     out_imm_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;
    logic             out_err_q,     out_err_d;
    logic             skid_valid_q,  skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,    skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,    skid_tag_d;
    logic             skid_err_q,    skid_err_d;
    logic             in_ready_q,    in_ready_d;
    logic [7:0]       err_cnt_q,     err_cnt_d;

    logic             accept_s;
    logic             drain_s;
    logic [XLEN-1:0]  new_imm_s;
    logic             new_err_s;

    assign accept_s  = in_valid && in_ready_q && !flush;
    assign drain_s   = out_valid_q && out_ready;
    assign new_imm_s = gen_imm(in_ins, in_fmt);
    assign new_err_s = (in_fmt == FMT_RSV);

    // Next-state for output/skid registers, ready flag and error counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain_s && skid_valid_q) begin
            // in_ready is low while skid is full, so no accept can coincide.
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_tag_d    = skid_tag_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
        end else if (accept_s) begin
            if (!out_valid_q || drain_s) begin
                out_valid_d = 1'b1;
                out_imm_d   = new_imm_s;
                out_tag_d   = in_tag;
                out_err_d   = new_err_s;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = new_imm_s;
                skid_tag_d   = in_tag;
                skid_err_d   = new_err_s;
            end
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        in_ready_d = !skid_valid_d;

        if (accept_s && new_err_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers; async reset empties both entries and clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= {XLEN{1'b0}};
            out_tag_q    <= {TAG_W{1'b0}};
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= {XLEN{1'b0}};
            skid_tag_q   <= {TAG_W{1'b0}};
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            err_cnt_q    <= 8'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_fmt_err = out_err_q;
    assign err_count   = err_cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the next-generation core. It extends the four-format RV32 immediate extractor to XLEN 32 or 64, adds the U, shift-amount and CSR-zimm formats, and flags reserved selects. Each result is registered behind a valid/ready handshake with a one-entry skid buffer, so decode can stall without a combinational ready path. A saturating counter tracks reserved-format requests for debug.

## Interface
- XLEN, 32, immediate width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried alongside each immediate (rd, PC slot id, etc.).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; drops all held entries.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted; registered, equals !skid_valid.
- in_ins  in  32  instruction word.
- in_fmt  in  3  format select (encoding below).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the result.
- out_fmt_err  out  1  result came from a reserved format select.
- err_count  out  8  saturating count of accepted reserved-format requests.

## Operation
- Format encoding (low two codes bit-compatible with the existing 2-bit imm_src):
  - 000 I: sext(ins[31:20]).
  - 001 S: sext({ins[31:25], ins[11:7]}).
  - 010 B: sext({ins[31], ins[7], ins[30:25], ins[11:8], 0}).
  - 011 J: sext({ins[31], ins[19:12], ins[20], ins[30:21], 0}).
  - 100 U: sext({ins[31:12], 12'b0}) (sign-extension only matters for XLEN=64).
  - 101 SHAMT: zext(ins[24:20]) for XLEN=32, zext(ins[25:20]) for XLEN=64.
  - 110 ZIMM: zext(ins[19:15]).
  - 111 reserved: imm = 0, fmt_err = 1.
- All sign extension is from ins[31] to full XLEN.
- Storage: output register (out_*) and skid register, each with its own valid bit.
- Accept = in_valid && in_ready && !flush. Drain = out_valid && out_ready.
- On accept:
  - If the output register is empty or draining this cycle and skid is empty, load the output register.
  - Otherwise load skid.
- On drain with skid full: skid moves to the output register and skid empties.
- Order is strictly FIFO; no result is duplicated or lost.
- Accept with a reserved format increments err_count, saturating at 255. A flush does not clear err_count; only reset does.
- flush: the next edge clears both valid bits. A request presented in the flush cycle is not accepted and err_count does not change.

## Timing
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_fmt_err=0, err_count=0, skid empty, in_ready=1.
- Latency: accept in cycle N, and out_valid=1 with data from cycle N+1.
- Throughput: one result per cycle while out_ready=1.
- Stall:
  - The first accept while stalled lands in skid.
  - in_ready drops at the next edge.
  - in_ready returns to 1 one edge after the drain that empties skid.
- out_* hold stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid empty: the new entry goes to the output register and out_valid stays 1.
- Async reset mid-stall discards both entries immediately.

## Test plan
- I and S formats, XLEN=32:
  - ins=0xFFF00093, fmt=000 -> out_imm=0xFFFFFFFF, one cycle later.
  - ins=0xFE512E23, fmt=001 -> 0xFFFFFFFC.
- B, U and ZIMM formats:
  - ins=0xFE000CE3, fmt=010 -> 0xFFFFFFF8.
  - ins=0x123450B7, fmt=100 -> 0x12345000.
  - With XLEN=64: ins=0x800000B7, fmt=100 -> 0xFFFFFFFF80000000.
  - ins=0x000FD073, fmt=110 -> 0x1F.
- SHAMT, XLEN=64: ins=0x03F0D093, fmt=101 -> 0x3F. The same word with XLEN=32 -> 0x1F.
- Back-pressure:
  - Hold out_ready=0 and stream tags 1,2,3.
  - Tag 1 is held in the output register and tag 2 in skid; in_ready=0 and tag 3 is not accepted.
  - Release out_ready: outputs appear in order 1,2,3 with no gaps once unstalled.
- Reserved and saturation:
  - 300 accepts with fmt=111 -> each output has out_imm=0 and out_fmt_err=1; err_count=255.
  - Flush leaves err_count=255; reset clears it to 0.
- Flush and reset:
  - With both entries full, pulse flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no result for the flushed request.
  - Asserting rst_n=0 mid-stall clears all outputs asynchronously.
